// File: rtl/gate_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gate_bist_pkg
//  Purpose  : Shared types and constants for the gate BIST checker.
//             - bist_state_t : controller states
//             - vec_count()  : size of the input vector space (2**n)
//             - TT_*         : reference truth tables for common 2-input gates
//  Revision : 1.0 - initial release
// ============================================================================
package gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } bist_state_t;

    // Width of the settle counter; it must hold SETTLE-1 for SETTLE up to 15.
    localparam int SETTLE_CNT_W = 4;

    // Bit i of a truth table is the gate output for input vector i.
    localparam logic [3:0] TT_AND2 = 4'b1000;
    localparam logic [3:0] TT_OR2  = 4'b1110;
    localparam logic [3:0] TT_XOR2 = 4'b0110;

    function automatic int vec_count(input int n_in);
        return 1 << n_in;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_bist_settle_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : gate_bist_settle_cnt
//  Purpose  : Loadable down-counter with a zero flag; times the settle window
//             each input vector is held before its response is sampled.
//  Ports    : clk, rst (async, active-high)
//             i_load / i_load_val : load a new count (has priority)
//             i_dec               : decrement, saturating at zero
//             o_zero              : count is zero
//  Revision : 1.0 - initial release
// ============================================================================
module gate_bist_settle_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/gate_bist_checker.sv
`default_nettype none
// ============================================================================
//  Module   : gate_bist_checker
//  Purpose  : BIST controller for a small combinational gate. Walks every
//             input vector, holds each for SETTLE cycles, samples the gate
//             response and compares it with EXP_TT. Reports mismatch count,
//             first failing vector and an overall pass flag.
//  Ports    : clk, reset (async, active-high), start
//             vec        : vector driven into the gate under test
//             resp       : gate under test output
//             busy, done, pass, err_count, fail_vec, fail_valid : results
//  Options  : GATE_BIST_STOP_ON_FAIL_EN - when defined, the first mismatch
//             ends the run immediately (remaining vectors skipped).
//  Revision : 1.0 - initial release
// ============================================================================
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter int                   N_IN   = 2,
    parameter logic [(1<<N_IN)-1:0] EXP_TT = TT_AND2,
    parameter int                   SETTLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [N_IN-1:0] vec,
    input  logic            resp,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] fail_vec,
    output logic            fail_valid
);

    localparam int                      c_NVEC      = vec_count(N_IN);
    localparam logic [N_IN-1:0]         c_LAST_VEC  = N_IN'(c_NVEC - 1);
    localparam logic [SETTLE_CNT_W-1:0] c_SETTLE_LD = SETTLE_CNT_W'(SETTLE - 1);

    bist_state_t     r_state, w_state_nxt;
    logic [N_IN-1:0] r_vec, w_vec_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_done, w_done_nxt;
    logic            r_pass, w_pass_nxt;
    logic [N_IN:0]   r_err_count, w_err_nxt;
    logic [N_IN-1:0] r_fail_vec, w_fail_vec_nxt;
    logic            r_fail_valid, w_fail_valid_nxt;

    logic            w_cnt_load;
    logic            w_cnt_dec;
    logic            w_cnt_zero;
    logic            w_mismatch;
    logic            w_stop;

    gate_bist_settle_cnt #(
        .WIDTH (SETTLE_CNT_W)
    ) u_settle_cnt (
        .clk        (clk),
        .rst        (reset),
        .i_load     (w_cnt_load),
        .i_load_val (c_SETTLE_LD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    assign w_mismatch = (resp != EXP_TT[r_vec]);

`ifdef GATE_BIST_STOP_ON_FAIL_EN
    assign w_stop = w_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_vec_nxt        = r_vec;
        w_busy_nxt       = r_busy;
        w_done_nxt       = r_done;
        w_pass_nxt       = r_pass;
        w_err_nxt        = r_err_count;
        w_fail_vec_nxt   = r_fail_vec;
        w_fail_valid_nxt = r_fail_valid;
        w_cnt_load       = 1'b0;
        w_cnt_dec        = 1'b0;

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_nxt      = APPLY;
                    w_vec_nxt        = '0;
                    w_err_nxt        = '0;
                    w_fail_valid_nxt = 1'b0;
                    w_busy_nxt       = 1'b1;
                    w_done_nxt       = 1'b0;
                    w_cnt_load       = 1'b1;
                end
            end
            APPLY: begin
                if (w_cnt_zero) begin
                    w_state_nxt = SAMPLE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            SAMPLE: begin
                if (w_mismatch) begin
                    w_err_nxt = r_err_count + 1'b1;
                    if (!r_fail_valid) begin
                        w_fail_vec_nxt   = r_vec;
                        w_fail_valid_nxt = 1'b1;
                    end
                end
                // The last vector ends the run without incrementing vec, so
                // vec never wraps and still shows the final vector in DONE.
                if ((r_vec == c_LAST_VEC) || w_stop) begin
                    w_state_nxt = DONE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (w_err_nxt == '0);
                end else begin
                    w_state_nxt = APPLY;
                    w_vec_nxt   = r_vec + 1'b1;
                    w_cnt_load  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_vec        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_fail_vec   <= '0;
            r_fail_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_vec        <= w_vec_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_pass       <= w_pass_nxt;
            r_err_count  <= w_err_nxt;
            r_fail_vec   <= w_fail_vec_nxt;
            r_fail_valid <= w_fail_valid_nxt;
        end
    end

    assign vec        = r_vec;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign fail_vec   = r_fail_vec;
    assign fail_valid = r_fail_valid;

endmodule
`default_nettype wire

// File: tb/tb_gate_bist_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gate_bist_checker
//  Purpose  : Self-checking bench for gate_bist_checker. Two instances (SETTLE
//             1 and 3) share start/reset; each gate under test is emulated by
//             a bench-chosen truth table. A time-based model predicts every
//             output each cycle; literal checks pin the key scenarios.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gate_bist_checker;

    localparam logic [3:0] c_EXP = 4'b1000;   // AND2
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    localparam bit c_STOP = 1'b1;
`else
    localparam bit c_STOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] resp_tt;

    logic [1:0] vec_w        [2];
    logic       resp_w       [2];
    logic       busy_w       [2];
    logic       done_w       [2];
    logic       pass_w       [2];
    logic [2:0] err_w        [2];
    logic [1:0] fail_vec_w   [2];
    logic       fail_valid_w [2];

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int c_S = (g == 0) ? 1 : 3;

        assign resp_w[g] = resp_tt[vec_w[g]];

        gate_bist_checker #(
            .N_IN   (2),
            .EXP_TT (4'b1000),
            .SETTLE (c_S)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start),
            .vec        (vec_w[g]),
            .resp       (resp_w[g]),
            .busy       (busy_w[g]),
            .done       (done_w[g]),
            .pass       (pass_w[g]),
            .err_count  (err_w[g]),
            .fail_vec   (fail_vec_w[g]),
            .fail_valid (fail_valid_w[g])
        );

        // Model: phase 0 idle, 1 running, 2 done. m_t counts edges since the
        // start edge; vector m_vec is judged on every (SETTLE+1)-th edge.
        int         m_phase;
        int         m_t;
        logic [3:0] m_tt;
        logic [1:0] m_vec;
        logic [2:0] m_err;
        logic [1:0] m_fv;
        logic       m_fvalid;
        logic       m_pass;
        logic       m_samp;
        logic       m_mis;

        assign m_samp = (m_phase == 1) && (((m_t + 1) % (c_S + 1)) == 0);
        assign m_mis  = (m_tt[m_vec] != c_EXP[m_vec]);

        always @(posedge clk or posedge reset) begin
            if (reset) begin
                m_phase <= 0; m_t <= 0; m_tt <= '0; m_vec <= '0;
                m_err <= '0; m_fv <= '0; m_fvalid <= 1'b0; m_pass <= 1'b0;
            end else if ((m_phase != 1) && start) begin
                m_phase <= 1; m_t <= 0; m_tt <= resp_tt; m_vec <= '0;
                m_err <= '0; m_fvalid <= 1'b0;
            end else if (m_phase == 1) begin
                m_t <= m_t + 1;
                if (m_samp) begin
                    if (m_mis) begin
                        m_err <= m_err + 3'd1;
                        if (!m_fvalid) begin
                            m_fvalid <= 1'b1;
                            m_fv     <= m_vec;
                        end
                    end
                    if ((m_vec == 2'd3) || (c_STOP && m_mis)) begin
                        m_phase <= 2;
                        m_pass  <= ((m_err + 3'(m_mis)) == 3'd0);
                    end else begin
                        m_vec <= m_vec + 2'd1;
                    end
                end
            end
        end

        always @(negedge clk) begin
            chk($sformatf("busy[%0d]", g), 32'(busy_w[g]), 32'(m_phase == 1));
            chk($sformatf("done[%0d]", g), 32'(done_w[g]), 32'(m_phase == 2));
            chk($sformatf("vec[%0d]", g), 32'(vec_w[g]), 32'(m_vec));
            chk($sformatf("err_count[%0d]", g), 32'(err_w[g]), 32'(m_err));
            chk($sformatf("fail_valid[%0d]", g), 32'(fail_valid_w[g]), 32'(m_fvalid));
            if (m_fvalid)
                chk($sformatf("fail_vec[%0d]", g), 32'(fail_vec_w[g]), 32'(m_fv));
            if (m_phase == 2)
                chk($sformatf("pass[%0d]", g), 32'(pass_w[g]), 32'(m_pass));
        end
    end

    // Launch one run on both instances; returns edges from start to done.
    task automatic run(input logic [3:0] tt, output int t0, output int t3);
        bit seen;
        @(negedge clk);
        resp_tt = tt;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = 0;
        t3 = 0;
        seen = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (done_w[0] && (t0 == 0)) t0 = n;
            if (done_w[1] && (t3 == 0)) t3 = n;
            if ((t0 != 0) && (t3 != 0)) begin
                seen = 1'b1;
                break;
            end
        end
        chk("run_completes", 32'(seen), 32'd1);
    endtask

    task automatic chk_reset_vals(input int g, input string tag);
        chk({tag, "_vec"}, 32'(vec_w[g]), 32'd0);
        chk({tag, "_busy"}, 32'(busy_w[g]), 32'd0);
        chk({tag, "_done"}, 32'(done_w[g]), 32'd0);
        chk({tag, "_pass"}, 32'(pass_w[g]), 32'd0);
        chk({tag, "_err"}, 32'(err_w[g]), 32'd0);
        chk({tag, "_fail_vec"}, 32'(fail_vec_w[g]), 32'd0);
        chk({tag, "_fail_valid"}, 32'(fail_valid_w[g]), 32'd0);
    endtask

    initial begin
        int  t0, t3;
        bit  hit;
        reset   = 1'b1;
        start   = 1'b0;
        resp_tt = 4'b1000;
        repeat (2) @(negedge clk);
        chk_reset_vals(0, "rst0");
        chk_reset_vals(1, "rst1");
        reset = 1'b0;
        @(negedge clk);

        // Correct AND gate
        run(4'b1000, t0, t3);
        chk("and_latency_s1", 32'(t0), 32'd8);
        chk("and_latency_s3", 32'(t3), 32'd16);
        chk("and_pass", 32'(pass_w[0]), 32'd1);
        chk("and_err", 32'(err_w[0]), 32'd0);
        chk("and_fail_valid", 32'(fail_valid_w[0]), 32'd0);
        chk("and_vec", 32'(vec_w[0]), 32'd3);

        // Output stuck at 0: only vector 3 disagrees
        run(4'b0000, t0, t3);
        chk("sa0_pass", 32'(pass_w[0]), 32'd0);
        chk("sa0_err", 32'(err_w[0]), 32'd1);
        chk("sa0_fail_vec", 32'(fail_vec_w[0]), 32'd3);
        chk("sa0_fail_valid", 32'(fail_valid_w[0]), 32'd1);

        // OR gate instead of AND: vectors 1 and 2 disagree
        run(4'b1110, t0, t3);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        chk("or_err", 32'(err_w[0]), 32'd1);
`else
        chk("or_err", 32'(err_w[0]), 32'd2);
`endif
        chk("or_fail_vec", 32'(fail_vec_w[0]), 32'd1);
        chk("or_pass", 32'(pass_w[0]), 32'd0);

`ifdef GATE_BIST_STOP_ON_FAIL_EN
        // Stuck at 1: vector 0 fails first, run ends after two edges
        run(4'b1111, t0, t3);
        chk("sa1_latency", 32'(t0), 32'd2);
        chk("sa1_err", 32'(err_w[0]), 32'd1);
        chk("sa1_fail_vec", 32'(fail_vec_w[0]), 32'd0);
        chk("sa1_pass", 32'(pass_w[0]), 32'd0);
`endif

        // Reset mid-run while vector 2 is applied
        @(negedge clk);
        resp_tt = 4'b1000;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (vec_w[0] == 2'd2) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("midrun_reach_vec2", 32'(hit), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_reset_vals(0, "midrst0");
        chk_reset_vals(1, "midrst1");
        @(negedge clk);
        reset = 1'b0;
        run(4'b1000, t0, t3);
        chk("after_rst_pass", 32'(pass_w[0]), 32'd1);
        chk("after_rst_err", 32'(err_w[0]), 32'd0);

        // Random gate behaviours, checked by the per-cycle model
        for (int i = 0; i < 12; i++) begin
            run(4'($urandom_range(0, 15)), t0, t3);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
